// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and single-outstanding instruction fetch
// sequencer. Requests one word at a time from instruction memory over a
// req/ack port, then holds the fetched word for decode until it is taken.
//
// Handshake rules:
//  - imem port: imem_req/imem_addr are held stable from the cycle imem_req
//    rises until the cycle imem_ack is sampled high; imem_ack is only
//    meaningful while a request is pending (state REQ) and is ignored otherwise.
//  - decode port: instr/instr_pc are stable while instr_valid=1; a transfer
//    happens on a rising edge where instr_valid & instr_ready & ~stall, and
//    instr_valid never drops without a transfer (except on reset).
module pc_fetch_unit #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCS,
  input  logic [ADDR_W-1:0]  PCTarget,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic               accept;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  redirect_pc;

  // Decode takes the held instruction this cycle.
  assign accept      = instr_valid & instr_ready & ~stall;
  // Sequential successor; wraps silently at the top of the address space.
  assign pc_inc      = pc + ADDR_W'(4);
  // Redirect target is forced word aligned.
  assign redirect_pc = PCTarget & ~ADDR_W'(3);

  // The fetch address is always the current PC; only meaningful with imem_req.
  assign imem_addr = pc;
  assign dbg_state = state;

  // Fetch sequencer: BOOT idles one cycle, REQ waits for memory, HOLD waits
  // for decode; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // PCS/PCTarget only matter on the accepting edge; pc already
          // points at instr_pc+4 for the fall-through case.
          if (accept) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
            if (PCS) begin
              pc <= redirect_pc;
            end
          end
        end
        default: begin
          state       <= BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
